// File: rtl/prt_dp_app_pkg.sv
// rtl/prt_dp_app_pkg.sv - shared types and constants for the application RAM arbiter
package prt_dp_app_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_e;

  localparam logic [31:0] ERR_DAT_DEFAULT = 32'hdeadbeef;

endpackage

// File: rtl/prt_dp_app_ram_arb_if.sv
// rtl/prt_dp_app_ram_arb_if.sv - RAM-interface bus shared by requesters and the RAM port
interface prt_dp_app_ram_arb_if #(
  parameter int ADR_W = 16
);
  logic [ADR_W-1:0] adr;
  logic             wr;
  logic [3:0]       msk;
  logic [31:0]      wdat;
  logic             req;
  logic [31:0]      rdat;
  logic             ack;

  modport master (output adr, wr, msk, wdat, req, input rdat, ack);
  modport slave  (input adr, wr, msk, wdat, req, output rdat, ack);
endinterface

// File: rtl/prt_dp_app_ram_arb_rr.sv
// rtl/prt_dp_app_ram_arb_rr.sv - two-requester round-robin grant with a priority pointer
module prt_dp_app_ram_arb_rr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant_vld,
  output logic       grant_idx,
  output logic       ptr
);

  // ptr names the port that wins the next tie; reset favours port 0
  always_comb begin
    grant_vld = |req;
    grant_idx = (req == 2'b11) ? ptr : req[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update && grant_vld) begin
      ptr <= ~grant_idx;
    end
  end

endmodule

// File: rtl/prt_dp_app_ram_arb.sv
// rtl/prt_dp_app_ram_arb.sv - two-master round-robin arbiter for the shared application RAM
module prt_dp_app_ram_arb
  import prt_dp_app_pkg::*;
#(
  parameter int          P_ADR_WIDTH = 16,
  parameter int          P_TIMEOUT   = 255,
  parameter logic [31:0] P_ERR_DAT   = ERR_DAT_DEFAULT
) (
  input  logic                        clk_in,
  input  logic                        rstn_in,
  prt_dp_app_ram_arb_if.slave         m0,
  prt_dp_app_ram_arb_if.slave         m1,
  prt_dp_app_ram_arb_if.master        ram,
  output logic                        err_out
);

  localparam logic [1:0] IDLE = ARB_IDLE;
  localparam logic [1:0] BUSY = ARB_BUSY;
  localparam logic [1:0] ACK  = ARB_ACK;
  localparam int WD_W = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;

  logic [1:0]             state;
  logic                   gnt;
  logic [WD_W-1:0]        wd;
  logic [WD_W:0]          wd_nxt;
  logic                   timeout;
  logic                   grant_vld;
  logic                   grant_idx;
  logic                   rr_ptr;
  logic [P_ADR_WIDTH-1:0] adr_q;

  prt_dp_app_ram_arb_rr u_rr (
    .clk       (clk_in),
    .rst_n     (rstn_in),
    .req       ({m1.req, m0.req}),
    .update    (state == IDLE),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .ptr       (rr_ptr)
  );

  // The extra watchdog bit lets the compare see the terminal count without wrapping
  assign wd_nxt  = {1'b0, wd} + (WD_W + 1)'(1);
  assign timeout = (P_TIMEOUT != 0) && (wd_nxt == (WD_W + 1)'(P_TIMEOUT));
  assign ram.adr = adr_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      wd       <= '0;
      adr_q    <= '0;
      ram.wr   <= 1'b0;
      ram.msk  <= 4'd0;
      ram.wdat <= 32'd0;
      ram.req  <= 1'b0;
      m0.rdat  <= 32'd0;
      m0.ack   <= 1'b0;
      m1.rdat  <= 32'd0;
      m1.ack   <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      m0.ack  <= 1'b0;
      m1.ack  <= 1'b0;
      err_out <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            adr_q    <= grant_idx ? m1.adr  : m0.adr;
            ram.wr   <= grant_idx ? m1.wr   : m0.wr;
            ram.msk  <= grant_idx ? m1.msk  : m0.msk;
            ram.wdat <= grant_idx ? m1.wdat : m0.wdat;
            ram.req  <= 1'b1;
            gnt      <= grant_idx;
            wd       <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // A real ack outranks a timeout landing on the same cycle
          if (ram.ack || timeout) begin
            ram.req <= 1'b0;
            err_out <= ~ram.ack;
            state   <= ACK;
            if (gnt) begin
              m1.rdat <= ram.ack ? ram.rdat : P_ERR_DAT;
              m1.ack  <= 1'b1;
            end else begin
              m0.rdat <= ram.ack ? ram.rdat : P_ERR_DAT;
              m0.ack  <= 1'b1;
            end
          end else if (P_TIMEOUT != 0) begin
            wd <= wd_nxt[WD_W-1:0];
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_dp_app_ram_arb.sv
// tb/tb_prt_dp_app_ram_arb.sv - scoreboard bench for the application RAM arbiter
module tb_prt_dp_app_ram_arb;

  logic clk;
  logic rst_n;
  logic err0;
  logic err1;
  int   total;
  int   bad;

  typedef struct {
    bit          port;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];

  prt_dp_app_ram_arb_if #(.ADR_W(16)) m0_if ();
  prt_dp_app_ram_arb_if #(.ADR_W(16)) m1_if ();
  prt_dp_app_ram_arb_if #(.ADR_W(16)) ram_if ();
  prt_dp_app_ram_arb_if #(.ADR_W(16)) t0_if ();
  prt_dp_app_ram_arb_if #(.ADR_W(16)) t1_if ();
  prt_dp_app_ram_arb_if #(.ADR_W(16)) tr_if ();

  prt_dp_app_ram_arb dut (
    .clk_in  (clk),
    .rstn_in (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .ram     (ram_if),
    .err_out (err0)
  );

  prt_dp_app_ram_arb #(.P_TIMEOUT(8)) dut_to (
    .clk_in  (clk),
    .rstn_in (rst_n),
    .m0      (t0_if),
    .m1      (t1_if),
    .ram     (tr_if),
    .err_out (err1)
  );

  logic [120:0] main_outs;
  assign main_outs = {ram_if.req, ram_if.wr, ram_if.msk, ram_if.adr, ram_if.wdat,
                      m0_if.ack, m0_if.rdat, m1_if.ack, m1_if.rdat, err0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Every requester ack on the main arbiter is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n && (m0_if.ack || m1_if.ack)) begin
      total++;
      if (m0_if.ack && m1_if.ack) begin
        bad++;
        $display("FAIL sb_dual_ack: got both acks, want one");
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got ack on port %0d, want none", m1_if.ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({m1_if.ack, m1_if.ack ? m1_if.rdat : m0_if.rdat} !== {e.port, e.dat}) begin
          bad++;
          $display("FAIL sb_ack: got port %0d dat %h, want port %0d dat %h",
                   m1_if.ack, m1_if.ack ? m1_if.rdat : m0_if.rdat, e.port, e.dat);
        end
      end
    end
  end

  task automatic init_inputs;
    m0_if.req = 0; m0_if.adr = 0; m0_if.wr = 0; m0_if.msk = 0; m0_if.wdat = 0;
    m1_if.req = 0; m1_if.adr = 0; m1_if.wr = 0; m1_if.msk = 0; m1_if.wdat = 0;
    t0_if.req = 0; t0_if.adr = 0; t0_if.wr = 0; t0_if.msk = 0; t0_if.wdat = 0;
    t1_if.req = 0; t1_if.adr = 0; t1_if.wr = 0; t1_if.msk = 0; t1_if.wdat = 0;
    ram_if.ack = 0; ram_if.rdat = 0;
    tr_if.ack = 0; tr_if.rdat = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    init_inputs();
    #3;
    total++;
    if ({main_outs, err1} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got %h, want 0", {main_outs, err1});
    end
    step; step;
    rst_n = 1;
    step;
  endtask

  task automatic test_single_write;
    step;
    m0_if.req = 1; m0_if.adr = 16'h0010; m0_if.wr = 1; m0_if.msk = 4'b0011;
    m0_if.wdat = 32'h12345678;
    ram_if.rdat = 32'h0f0f0f0f;
    sb.push_back('{1'b0, 32'h0f0f0f0f});
    step;
    total++;
    if ({ram_if.req, ram_if.adr, ram_if.wr, ram_if.msk, ram_if.wdat, m0_if.ack}
        !== {1'b1, 16'h0010, 1'b1, 4'b0011, 32'h12345678, 1'b0}) begin
      bad++;
      $display("FAIL wr_cmd: got req %b adr %h wr %b msk %b dat %h ack %b, want 1 0010 1 0011 12345678 0",
               ram_if.req, ram_if.adr, ram_if.wr, ram_if.msk, ram_if.wdat, m0_if.ack);
    end
    ram_if.ack = 1;
    step;
    total++;
    if ({m0_if.ack, ram_if.req} !== 2'b10) begin
      bad++;
      $display("FAIL wr_ack: got ack %b ram_req %b, want 1 0", m0_if.ack, ram_if.req);
    end
    ram_if.ack = 0; m0_if.req = 0; m0_if.wr = 0;
    step;
    step;
    total++;
    if ({m0_if.ack, ram_if.req} !== 2'b00) begin
      bad++;
      $display("FAIL wr_after: got ack %b ram_req %b, want 0 0", m0_if.ack, ram_if.req);
    end
  endtask

  task automatic test_rr_tie;
    int n0, n1, last;
    rst_n = 0;
    step;
    rst_n = 1;
    for (int k = 0; k < 8; k++)
      sb.push_back('{k[0], {16'ha5a5, 16'((k % 2) * 256 + k / 2)}});
    m0_if.req = 1; m0_if.adr = 16'h0000; m0_if.wr = 0; m0_if.msk = 4'hf;
    m1_if.req = 1; m1_if.adr = 16'h0100; m1_if.wr = 0; m1_if.msk = 4'hf;
    n0 = 0; n1 = 0; last = -1;
    for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
      step;
      if (ram_if.req) begin
        ram_if.ack  = 1;
        ram_if.rdat = {16'ha5a5, ram_if.adr};
      end else begin
        ram_if.ack = 0;
      end
      if (m0_if.ack || m1_if.ack) begin
        if (last >= 0) begin
          total++;
          if (c - last != 3) begin
            bad++;
            $display("FAIL rr_spacing: got %0d cycles, want 3", c - last);
          end
        end
        last = c;
      end
      if (m0_if.ack) begin
        n0++;
        if (n0 == 4) m0_if.req = 0;
        else m0_if.adr = 16'(n0);
      end
      if (m1_if.ack) begin
        n1++;
        if (n1 == 4) m1_if.req = 0;
        else m1_if.adr = 16'h0100 + 16'(n1);
      end
    end
    ram_if.ack = 0;
    total++;
    if (n0 != 4 || n1 != 4) begin
      bad++;
      $display("FAIL rr_done: got %0d/%0d acks, want 4/4", n0, n1);
    end
    step; step;
  endtask

  task automatic test_slow_read;
    step;
    m1_if.req = 1; m1_if.adr = 16'h0bcd; m1_if.wr = 0; m1_if.msk = 4'hf;
    ram_if.rdat = 32'h0;
    sb.push_back('{1'b1, 32'hcafef00d});
    for (int c = 1; c <= 10; c++) begin
      step;
      total++;
      if ({ram_if.req, ram_if.adr, ram_if.wr, ram_if.msk, m1_if.ack}
          !== {1'b1, 16'h0bcd, 1'b0, 4'hf, 1'b0}) begin
        bad++;
        $display("FAIL slow_hold c%0d: got req %b adr %h wr %b msk %h ack %b, want 1 0bcd 0 f 0",
                 c, ram_if.req, ram_if.adr, ram_if.wr, ram_if.msk, m1_if.ack);
      end
      if (c == 10) begin
        ram_if.ack = 1; ram_if.rdat = 32'hcafef00d;
      end
    end
    step;
    total++;
    if ({m1_if.ack, m1_if.rdat} !== {1'b1, 32'hcafef00d}) begin
      bad++;
      $display("FAIL slow_ack: got ack %b dat %h, want 1 cafef00d", m1_if.ack, m1_if.rdat);
    end
    ram_if.ack = 0; ram_if.rdat = 0; m1_if.req = 0;
    step; step;
  endtask

  task automatic test_timeout;
    step;
    t0_if.req = 1; t0_if.adr = 16'h0020; t0_if.wr = 0; t0_if.msk = 4'hf;
    for (int c = 1; c <= 8; c++) begin
      step;
      total++;
      if ({tr_if.req, t0_if.ack, err1} !== 3'b100) begin
        bad++;
        $display("FAIL to_wait c%0d: got req/ack/err %b%b%b, want 100", c, tr_if.req, t0_if.ack, err1);
      end
    end
    step;
    total++;
    if ({t0_if.ack, err1, tr_if.req, t0_if.rdat} !== {3'b110, 32'hdeadbeef}) begin
      bad++;
      $display("FAIL to_fire: got ack %b err %b req %b dat %h, want 1 1 0 deadbeef",
               t0_if.ack, err1, tr_if.req, t0_if.rdat);
    end
    t0_if.req = 0;
    step;
    total++;
    if ({t0_if.ack, err1} !== 2'b00) begin
      bad++;
      $display("FAIL to_pulse: got ack %b err %b, want 0 0", t0_if.ack, err1);
    end
    step;
    tr_if.ack = 1; tr_if.rdat = 32'h11111111;
    step;
    tr_if.ack = 0;
    total++;
    if ({t0_if.ack, t1_if.ack, err1, tr_if.req, t0_if.rdat} !== {4'b0000, 32'hdeadbeef}) begin
      bad++;
      $display("FAIL to_late: got acks %b%b err %b req %b dat %h, want 0 0 0 0 deadbeef",
               t0_if.ack, t1_if.ack, err1, tr_if.req, t0_if.rdat);
    end
    step;
  endtask

  task automatic test_ack_vs_timeout;
    step;
    t0_if.req = 1; t0_if.adr = 16'h0030;
    for (int c = 1; c <= 7; c++) step;
    step;
    tr_if.ack = 1; tr_if.rdat = 32'h5a5a1234;
    step;
    total++;
    if ({t0_if.ack, err1, t0_if.rdat} !== {2'b10, 32'h5a5a1234}) begin
      bad++;
      $display("FAIL tie_ack: got ack %b err %b dat %h, want 1 0 5a5a1234", t0_if.ack, err1, t0_if.rdat);
    end
    tr_if.ack = 0; t0_if.req = 0;
    step; step;
  endtask

  task automatic test_reset_busy;
    step;
    m0_if.req = 1; m0_if.adr = 16'h0040; m0_if.wr = 0; m0_if.msk = 4'hf;
    step; step;
    total++;
    if (ram_if.req !== 1'b1) begin
      bad++;
      $display("FAIL rb_busy: got ram_req %b, want 1", ram_if.req);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if (main_outs !== '0) begin
      bad++;
      $display("FAIL rb_async: got %h, want 0", main_outs);
    end
    m0_if.req = 0;
    step; step;
    rst_n = 1;
    step; step; step;
    total++;
    if ({m0_if.ack, m1_if.ack, ram_if.req} !== 3'b000) begin
      bad++;
      $display("FAIL rb_quiet: got acks %b%b req %b, want 000", m0_if.ack, m1_if.ack, ram_if.req);
    end
    sb.push_back('{1'b0, 32'h00000077});
    sb.push_back('{1'b1, 32'h00000088});
    m0_if.req = 1; m0_if.adr = 16'h0050;
    m1_if.req = 1; m1_if.adr = 16'h0150; m1_if.msk = 4'hf;
    ram_if.rdat = 32'h77;
    step;
    total++;
    if ({ram_if.req, ram_if.adr} !== {1'b1, 16'h0050}) begin
      bad++;
      $display("FAIL rb_tie: got req %b adr %h, want 1 0050", ram_if.req, ram_if.adr);
    end
    ram_if.ack = 1;
    step;
    ram_if.ack = 0; m0_if.req = 0;
    step; step;
    total++;
    if ({ram_if.req, ram_if.adr} !== {1'b1, 16'h0150}) begin
      bad++;
      $display("FAIL rb_next: got req %b adr %h, want 1 0150", ram_if.req, ram_if.adr);
    end
    ram_if.ack = 1; ram_if.rdat = 32'h88;
    step;
    ram_if.ack = 0; m1_if.req = 0;
    step; step;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_rr_tie();
    test_slow_read();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_busy();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_left: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule

// File: doc/prt_dp_app_ram_arb.md
# prt_dp_app_ram_arb

Two-port round-robin arbiter sharing one application RAM between two bus masters (e.g. the policy-maker CPU data port and the AUX/DPCD helper engine). Each master sees a RAM-interface slave port. The single RAM-interface master port drives the physical RAM or RAM controller. Accesses are registered in both directions. A watchdog terminates accesses the RAM never acknowledges.

## Interface
- P_ADR_WIDTH, 16, address width on all three ports
- P_TIMEOUT, 255, cycles in BUSY before forced termination; 0 disables the watchdog
- P_ERR_DAT, 32'hdeadbeef, read data returned on a timed-out access
- CLK_IN  in  1  system clock
- RSTN_IN  in  1  asynchronous active-low reset
- M0_ADR_IN / M1_ADR_IN  in  P_ADR_WIDTH  requester address
- M0_WR_IN / M1_WR_IN  in  1  1 = write, 0 = read
- M0_MSK_IN / M1_MSK_IN  in  4  byte-enable mask, bit n = byte n
- M0_DAT_IN / M1_DAT_IN  in  32  write data
- M0_REQ_IN / M1_REQ_IN  in  1  request, level
- M0_DAT_OUT / M1_DAT_OUT  out  32  read data, valid with ack
- M0_ACK_OUT / M1_ACK_OUT  out  1  single-cycle acknowledge
- RAM_ADR_OUT  out  P_ADR_WIDTH  granted address
- RAM_WR_OUT  out  1  granted write strobe level
- RAM_MSK_OUT  out  4  granted mask
- RAM_DAT_OUT  out  32  granted write data
- RAM_DAT_IN  in  32  read data from the RAM
- RAM_REQ_OUT  out  1  request to the RAM, held until ack or timeout
- RAM_ACK_IN  in  1  single-cycle RAM acknowledge
- ERR_OUT  out  1  one-cycle pulse on watchdog timeout

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE: sample M0_REQ_IN and M1_REQ_IN.
  - If only one is high, grant that port.
  - If both are high, grant the port not granted last (round-robin pointer).
  - On grant, latch the port's adr/wr/msk/dat into the RAM_* output registers, set RAM_REQ_OUT, store the grant index, update the pointer, clear the watchdog, and go to BUSY.
- BUSY: hold RAM_* stable. The watchdog increments each cycle.
  - RAM_ACK_IN = 1: clear RAM_REQ_OUT, register RAM_DAT_IN into the granted port's DAT_OUT, pulse its ACK_OUT, and go to ACK.
  - Watchdog reaches P_TIMEOUT (P_TIMEOUT ≠ 0): clear RAM_REQ_OUT, return P_ERR_DAT with ACK_OUT, pulse ERR_OUT, and go to ACK.
  - If ack and timeout fall on the same cycle, ack wins and ERR_OUT stays low.
- ACK: ACK_OUT is high for this single cycle. Unconditionally go to IDLE next cycle.
- Write accesses also return RAM_DAT_IN on DAT_OUT; requesters ignore it.
- Requester rule: keep REQ and the command stable from assertion until ACK, and drop REQ in the cycle after ACK. A REQ still high in IDLE is a new access.
- RAM_ACK_IN outside BUSY is ignored, including a late ack after timeout.
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs return to 0.
  - The pointer is set so M0 wins the first tie.
  - Any in-flight access is abandoned without ack.
- The non-granted port's DAT_OUT holds its last value and its ACK_OUT stays 0.

## Timing
- Cycle 0: REQ sampled in IDLE.
- Cycle 1: RAM_REQ_OUT high, command valid.
- Cycle k (k ≥ 1): RAM_ACK_IN.
- Cycle k+1: ACK_OUT and DAT_OUT valid.
- Cycle k+2: IDLE, new arbitration.
- Minimum access, with RAM ack in cycle 1: master ack in cycle 2, next grant in cycle 3. Peak throughput is one access per 3 cycles.
- Timeout: RAM_REQ_OUT drops and ACK_OUT pulses at BUSY cycle P_TIMEOUT + 1 after grant.
- Watchdog width is clog2(P_TIMEOUT+1). It must not wrap.
- No combinational path from any input to any output.

## Structure
- The package prt_dp_app_pkg holds the FSM state enum (IDLE, BUSY, ACK) and the default error-data constant.
- Sub-module prt_dp_app_ram_arb_rr: 2-requester round-robin grant logic (req[1:0], update, grant index, pointer). It is reusable when the arbiter is widened to more ports.
- The top level contains the FSM, the command/data registers, and the watchdog.

## Test plan
- Single M0 write: adr 0x0010, msk 4'b0011, dat 0x12345678, RAM acks in cycle 1. Expect RAM_* to match from cycle 1, M0_ACK_OUT in cycle 2 only, and M1_ACK_OUT never.
- Simultaneous requests straight out of reset, each master repeating 4 reads. Expect grant order M0, M1, M0, M1, … and ACK_OUT 3 cycles apart with zero-wait RAM.
- M1 read with RAM ack after 10 cycles returning 0xCAFEF00D. Expect M1_DAT_OUT = 0xCAFEF00D with M1_ACK_OUT in cycle 11, and RAM command stable for cycles 1–10.
- P_TIMEOUT = 8, RAM never acks. Expect ERR_OUT and M0_ACK_OUT pulsing together with M0_DAT_OUT = 0xDEADBEEF, and a late RAM_ACK_IN two cycles later ignored.
- Ack and timeout on the same cycle. Expect real RAM data returned and ERR_OUT = 0.
- RSTN_IN asserted mid-BUSY. Expect all outputs 0 immediately, no ack issued, and the next tie granted to M0.
